// File: rtl/acc_reg_ext_pkg.sv
// Shared types and constants for the extended SAP-1 accumulator.
// Flag vectors are packed {V, N, C, Z}, indexed by the FLAG_* constants.
package acc_reg_ext_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LOAD = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_INC  = 4'd4,
        OP_DEC  = 4'd5,
        OP_CLR  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_SAR  = 4'd9
    } opcode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int NUM_FLAGS = 4;
    localparam int FLAG_Z    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_N    = 2;
    localparam int FLAG_V    = 3;

endpackage

// File: rtl/acc_alu_comb.sv
// Combinational result and flag generation for the single-cycle ops (LOAD..CLR).
// Define ACC_REG_EXT_SATURATE_EN to clamp ADD/INC/SUB/DEC instead of wrapping.
module acc_alu_comb #(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o
);
    import acc_reg_ext_pkg::*;

    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] result;
    logic             is_sub;
    logic             is_arith;
    logic             carry;
    logic             ovf;

    always_comb begin
        operand  = b_i;
        is_sub   = 1'b0;
        is_arith = 1'b1;
        case (opcode_e'(op_i))
            OP_ADD: ;
            OP_SUB: is_sub = 1'b1;
            OP_INC: operand = WIDTH'(1);
            OP_DEC: begin
                operand = WIDTH'(1);
                is_sub  = 1'b1;
            end
            default: is_arith = 1'b0;
        endcase

        // Bit WIDTH of the zero-extended sum/difference is carry-out or borrow.
        wide  = is_sub ? ({1'b0, a_i} - {1'b0, operand})
                       : ({1'b0, a_i} + {1'b0, operand});
        raw   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
        ovf   = is_sub ? ((a_i[WIDTH-1] != operand[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]))
                       : ((a_i[WIDTH-1] == operand[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]));
        result = raw;
`ifdef ACC_REG_EXT_SATURATE_EN
        if (carry) begin
            result = is_sub ? '0 : '1;
        end
`else
`endif

        if (!is_arith) begin
            carry  = 1'b0;
            ovf    = 1'b0;
            result = (opcode_e'(op_i) == OP_LOAD) ? b_i : '0;
        end

        flags_o         = '0;
        flags_o[FLAG_Z] = (result == '0);
        flags_o[FLAG_C] = carry;
        flags_o[FLAG_N] = result[WIDTH-1];
        flags_o[FLAG_V] = ovf;
        result_o        = result;
    end

endmodule

// File: rtl/acc_reg_ext.sv
// Extended SAP-1 accumulator: opcode datapath, status flags and a bit-serial shifter.
// Optional build macro ACC_REG_EXT_SATURATE_EN (handled in acc_alu_comb).
module acc_reg_ext #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] bus,
    input  logic [SHW-1:0]   shamt,
    output logic             op_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v
);
    import acc_reg_ext_pkg::*;

    localparam logic [SHW-1:0] SH_MAX = SHW'(WIDTH);

    state_e           state_q;
    opcode_e          shop_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [3:0]       flags_q;
    logic             done_q;

    opcode_e          opc;
    logic [SHW-1:0]   shamt_d;
    logic [WIDTH-1:0] shift_a_d;
    logic             shift_out_d;
    logic [3:0]       shift_flags_d;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;

    acc_alu_comb #(.WIDTH(WIDTH)) u_alu (
        .op_i     (op),
        .a_i      (a_q),
        .b_i      (bus),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    always_comb begin
        opc     = opcode_e'(op);
        shamt_d = (shamt > SH_MAX) ? SH_MAX : shamt;

        shift_a_d   = a_q;
        shift_out_d = 1'b0;
        case (shop_q)
            OP_SHL: begin
                shift_a_d   = {a_q[WIDTH-2:0], 1'b0};
                shift_out_d = a_q[WIDTH-1];
            end
            OP_SHR: begin
                shift_a_d   = {1'b0, a_q[WIDTH-1:1]};
                shift_out_d = a_q[0];
            end
            OP_SAR: begin
                shift_a_d   = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
                shift_out_d = a_q[0];
            end
            default: ;
        endcase

        // Only applied on the final step; intermediate steps leave flags alone.
        shift_flags_d         = '0;
        shift_flags_d[FLAG_Z] = (shift_a_d == '0);
        shift_flags_d[FLAG_C] = shift_out_d;
        shift_flags_d[FLAG_N] = shift_a_d[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shop_q  <= OP_NOP;
            cnt_q   <= '0;
            a_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        case (opc)
                            OP_LOAD, OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_CLR: begin
                                a_q     <= alu_result;
                                flags_q <= alu_flags;
                            end
                            OP_SHL, OP_SHR, OP_SAR: begin
                                if (shamt_d == '0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    state_q <= SHIFT;
                                    cnt_q   <= shamt_d;
                                    shop_q  <= opc;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                SHIFT: begin
                    a_q   <= shift_a_d;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        flags_q <= shift_flags_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q == SHIFT);
    assign op_ready = (state_q != SHIFT);
    assign done     = done_q;
    assign out      = a_q;
    assign flag_z   = flags_q[FLAG_Z];
    assign flag_c   = flags_q[FLAG_C];
    assign flag_n   = flags_q[FLAG_N];
    assign flag_v   = flags_q[FLAG_V];

endmodule

// File: tb/tb_acc_reg_ext.sv
// Self-checking bench for acc_reg_ext (WIDTH=8): vector table for single-cycle ops,
// hand-written sequences for shifts, busy handshake and mid-shift reset.
module tb_acc_reg_ext;

    localparam int W   = 8;
    localparam int SHW = 4;

    logic           clk;
    logic           rst;
    logic           op_valid;
    logic [3:0]     op;
    logic [W-1:0]   bus;
    logic [SHW-1:0] shamt;
    logic           op_ready;
    logic           busy;
    logic           done;
    logic [W-1:0]   out;
    logic           flag_z;
    logic           flag_c;
    logic           flag_n;
    logic           flag_v;

    acc_reg_ext #(.WIDTH(W), .SHW(SHW)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .bus      (bus),
        .shamt    (shamt),
        .op_ready (op_ready),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_n   (flag_n),
        .flag_v   (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] bus;
        logic [W-1:0] exp_out;
        logic [3:0]   exp_flags;   // {V, N, C, Z}
    } vec_t;

    vec_t         vecs[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] trace [0:40];

    function automatic logic [3:0] flags();
        return {flag_v, flag_n, flag_c, flag_z};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] o, input logic [W-1:0] b,
                           input logic [W-1:0] eo, input logic [3:0] ef);
        vec_t v;
        v.op = o; v.bus = b; v.exp_out = eo; v.exp_flags = ef;
        vecs.push_back(v);
    endtask

    task automatic do_op(input logic [3:0] o, input logic [W-1:0] b);
        op = o; bus = b; shamt = '0; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
    endtask

    // Issue a shift, count busy cycles until done, then check result and the one-cycle done pulse.
    task automatic run_shift(input string name, input logic [3:0] o, input logic [SHW-1:0] sh,
                             input int exp_cycles, input logic [W-1:0] exp_out,
                             input logic [3:0] exp_flags);
        int busy_cnt;
        logic seen;
        busy_cnt = 0;
        seen = 1'b0;
        op = o; shamt = sh; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            trace[i] = out;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            step();
        end
        check({name, " done_seen"}, 32'(seen), 32'd1);
        check({name, " busy_cycles"}, busy_cnt, exp_cycles);
        check({name, " out"}, 32'(out), 32'(exp_out));
        check({name, " flags"}, 32'(flags()), 32'(exp_flags));
        check({name, " op_ready_at_done"}, 32'(op_ready), 32'd1);
        step();
        check({name, " done_one_cycle"}, 32'(done), 32'd0);
        $display("shift %s op=%0d shamt=%0d busy=%0d out=0x%02h flags=%b",
                 name, o, sh, busy_cnt, out, flags());
    endtask

    initial begin
        logic [W-1:0] shr_exp [0:3];
        int done_cnt;

        rst = 1'b1; op_valid = 1'b0; op = '0; bus = '0; shamt = '0;

        // Single-cycle op vectors; each row sees the accumulator left by the previous one.
        add_vec(4'd1,  8'h7F, 8'h7F, 4'b0000);   // LOAD
        add_vec(4'd2,  8'h01, 8'h80, 4'b1100);   // ADD -> signed overflow
        add_vec(4'd1,  8'h05, 8'h05, 4'b0000);
`ifdef ACC_REG_EXT_SATURATE_EN
        add_vec(4'd3,  8'h07, 8'h00, 4'b0011);   // SUB borrow clamps to 0
        add_vec(4'd1,  8'h00, 8'h00, 4'b0001);
        add_vec(4'd5,  8'h00, 8'h00, 4'b0011);   // DEC from 0 clamps
        add_vec(4'd1,  8'hFF, 8'hFF, 4'b0100);
        add_vec(4'd4,  8'h00, 8'hFF, 4'b0110);   // INC from FF clamps
        add_vec(4'd13, 8'h55, 8'hFF, 4'b0110);   // undefined opcode: no change
        add_vec(4'd0,  8'h55, 8'hFF, 4'b0110);   // NOP
`else
        add_vec(4'd3,  8'h07, 8'hFE, 4'b0110);   // SUB with borrow
        add_vec(4'd1,  8'h00, 8'h00, 4'b0001);
        add_vec(4'd5,  8'h00, 8'hFF, 4'b0110);   // DEC from 0
        add_vec(4'd1,  8'hFF, 8'hFF, 4'b0100);
        add_vec(4'd4,  8'h00, 8'h00, 4'b0011);   // INC from FF wraps
        add_vec(4'd13, 8'h55, 8'h00, 4'b0011);
        add_vec(4'd0,  8'h55, 8'h00, 4'b0011);
`endif
        add_vec(4'd6,  8'h33, 8'h00, 4'b0001);   // CLR
        add_vec(4'd1,  8'h80, 8'h80, 4'b0100);
        add_vec(4'd3,  8'h01, 8'h7F, 4'b1000);   // SUB -> signed overflow
        add_vec(4'd2,  8'h80, 8'hFF, 4'b0100);
`ifdef ACC_REG_EXT_SATURATE_EN
        add_vec(4'd2,  8'h01, 8'hFF, 4'b0110);   // ADD carry clamps to FF
`else
        add_vec(4'd2,  8'h01, 8'h00, 4'b0011);   // ADD carry wraps to 0
`endif

        step(); step();
        rst = 1'b0;
        check("reset out", 32'(out), 32'h0);
        check("reset flags", 32'(flags()), 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset op_ready", 32'(op_ready), 32'd1);
        $display("reset out=0x%02h flags=%b busy=%0d", out, flags(), busy);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].bus);
            check($sformatf("vec%0d out", i), 32'(out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d flags", i), 32'(flags()), 32'(vecs[i].exp_flags));
            check($sformatf("vec%0d done", i), 32'(done), 32'd0);
            check($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
            $display("vec %0d op=%0d bus=0x%02h out=0x%02h flags=%b",
                     i, vecs[i].op, vecs[i].bus, out, flags());
        end

        // SHL by 3 on 0x81, with per-cycle intermediate values.
        do_op(4'd1, 8'h81);
        run_shift("shl3", 4'd7, 4'd3, 3, 8'h08, 4'b0000);
        check("shl3 trace0", 32'(trace[0]), 32'h81);
        check("shl3 trace1", 32'(trace[1]), 32'h02);
        check("shl3 trace2", 32'(trace[2]), 32'h04);
        check("shl3 trace3", 32'(trace[3]), 32'h08);

        do_op(4'd1, 8'h81);
        run_shift("sar1", 4'd9, 4'd1, 1, 8'hC0, 4'b0110);
        run_shift("shl0", 4'd7, 4'd0, 0, 8'hC0, 4'b0110);
        do_op(4'd1, 8'h90);
        run_shift("sar3", 4'd9, 4'd3, 3, 8'hF2, 4'b0100);
        do_op(4'd1, 8'h01);
        run_shift("shl12", 4'd7, 4'd12, 8, 8'h00, 4'b0011);
        do_op(4'd1, 8'hFF);
        run_shift("shr8", 4'd8, 4'd8, 8, 8'h00, 4'b0011);

        // SHR 4 with a LOAD held valid throughout: ignored while busy, taken in the done cycle.
        do_op(4'd1, 8'hF0);
        shr_exp[0] = 8'hF0; shr_exp[1] = 8'h78; shr_exp[2] = 8'h3C; shr_exp[3] = 8'h1E;
        op = 4'd8; shamt = 4'd4; op_valid = 1'b1;
        step();
        op = 4'd1; bus = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold%0d op_ready", i), 32'(op_ready), 32'd0);
            check($sformatf("hold%0d out", i), 32'(out), 32'(shr_exp[i]));
            step();
        end
        check("hold done", 32'(done), 32'd1);
        check("hold done out", 32'(out), 32'h0F);
        check("hold done flags", 32'(flags()), 32'b0000);
        check("hold done op_ready", 32'(op_ready), 32'd1);
        step();
        op_valid = 1'b0;
        check("hold load out", 32'(out), 32'hAA);
        check("hold load flags", 32'(flags()), 32'b0100);
        check("hold load done", 32'(done), 32'd0);
        $display("hold shr4 then load out=0x%02h flags=%b", out, flags());

        // Reset during cycle 2 of a 5-step shift.
        do_op(4'd1, 8'hFF);
        op = 4'd7; shamt = 4'd5; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        check("midrst busy", 32'(busy), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst out", 32'(out), 32'h0);
        check("midrst flags", 32'(flags()), 32'h0);
        check("midrst busy_after", 32'(busy), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) done_cnt++;
            step();
        end
        check("midrst no_done", done_cnt, 0);
        $display("midrst out=0x%02h flags=%b busy=%0d", out, flags(), busy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_reg_ext.md
Name: acc_reg_ext

Overview:
- Parametrised next-generation SAP-1 accumulator (A) register.
- Adds an opcode-driven datapath (load/add/sub/inc/dec/clear), a status flag register and a multi-cycle serial shifter with busy/done handshake.
- Sits between the bus and the output/B-register logic. The controller issues one op per accepted cycle.

Parameters:
- WIDTH, 8, accumulator and bus width in bits (>=4).
- SHW, $clog2(WIDTH+1), width of the shift-amount port.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- op_valid  input  1  op/operand/shamt valid this cycle
- op  input  4  opcode (see Behaviour)
- bus  input  WIDTH  operand from the system bus
- shamt  input  SHW  shift amount for SHL/SHR/SAR
- op_ready  output  1  = !busy; an op is accepted when op_valid && op_ready
- busy  output  1  serial shift in progress
- done  output  1  one-cycle pulse: shift op completed
- out  output  WIDTH  accumulator contents, always driven
- flag_z, flag_c, flag_n, flag_v  output  1 each  zero / carry-borrow / negative (MSB) / signed overflow

Behaviour:
- Reset: clk and rst are a single clock and a synchronous, active-high reset. When rst is high at a rising edge:
  - out=0, all flags=0, busy=0, done=0, state=IDLE.
  - Reset overrides everything, including a shift in progress; no done pulse is emitted.
- Opcodes: 0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 INC, 5 DEC, 6 CLR, 7 SHL, 8 SHR (logical), 9 SAR (arithmetic). Codes 10-15 behave as NOP.
- Single-cycle ops (1-6), accepted at edge k; result on out and flags after edge k:
  - LOAD: A=bus.
  - ADD: A=A+bus.
  - SUB: A=A-bus.
  - INC: A=A+1.
  - DEC: A=A-1.
  - CLR: A=0.
  - Arithmetic is mod 2^WIDTH.
- Flags after single-cycle ops:
  - Z = (result==0); N = result[WIDTH-1].
  - ADD/INC: C = carry-out.
  - SUB/DEC: C = borrow (1 when the unsigned minuend < subtrahend).
  - ADD/SUB/INC/DEC: V = two's-complement overflow.
  - LOAD/CLR: C=0, V=0.
  - NOP: no state change.
- State machine, IDLE -> SHIFT -> IDLE:
  - Shift accepted with shamt=0: no change to A or flags, stays IDLE, done pulses on the next cycle.
  - shamt > WIDTH is clamped to WIDTH.
  - Shift accepted with n>=1: state=SHIFT, cnt=n, busy=1 from the next cycle.
  - Each edge in SHIFT: A shifts one bit and cnt decrements.
    - SHL inserts 0 at the LSB.
    - SHR inserts 0 at the MSB.
    - SAR replicates the MSB.
  - On the edge performing the last shift: state=IDLE, busy=0, done=1 for exactly one cycle.
  - busy is high for exactly n cycles.
- Flags after a shift completes:
  - C = last bit shifted out; Z and N from the final A; V=0.
  - Flags are not updated during intermediate steps.
- Handshake:
  - op_valid while busy is ignored, not queued.
  - A new op may be accepted in the same cycle done is high.
- out always reflects the register, including intermediate shift values.

Optional Feature:
- Macro: ACC_REG_EXT_SATURATE_EN.
- Defined: ADD/INC clamp to all-ones on carry-out; SUB/DEC clamp to 0 on borrow. C still reports the raw carry/borrow. V is computed on the unclamped result.
- Undefined: wrap-around arithmetic as above. Nothing else differs.

Decomposition:
- Package acc_reg_ext_pkg holds:
  - opcode enum (4-bit);
  - state enum {IDLE, SHIFT};
  - flag-bit index constants.
- One natural sub-module, acc_alu_comb: combinational result/flag computation for ops 1-6, parametrised on WIDTH; the saturate macro lives there.
- Sequencing, the shift counter and the registers stay in the top block.

Test Plan (WIDTH=8):
- rst, then LOAD 0x7F, ADD 0x01 -> out=0x80, N=1, V=1, C=0, Z=0.
- LOAD 0x05, SUB 0x07 -> out=0xFE, C=1 (borrow), N=1. With saturate macro defined -> out=0x00, C=1, Z=1.
- LOAD 0x81, SHL shamt=3 -> busy high exactly 3 cycles, out 0x02, 0x04, 0x08 per cycle, done one pulse, C=0. Repeat with SAR shamt=1 on 0x81 -> out=0xC0, C=1.
- During a SHR shamt=4, assert op_valid with LOAD 0xAA -> ignored, op_ready=0; the LOAD is accepted in the done cycle -> out=0xAA next cycle.
- Assert rst in mid-shift (cycle 2 of shamt=5) -> next cycle out=0, flags=0, busy=0, no done pulse. Also: shamt=12 is clamped to 8 -> busy 8 cycles.
- DEC from 0x00 -> out=0xFF, C=1. INC from 0xFF -> out=0x00, Z=1, C=1. Opcode 13 and NOP -> no change to out or flags.
